// File: rtl/alu_mc_core.sv
// alu_mc_core: multi-cycle ALU with a GPR file and an SGPR that holds the multiply high half.
// Optional macro AU_SAT_EN: unsigned saturation on add/sub with a sat pulse.
module alu_mc_core #(
   parameter int DATA_W = 16,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ins_valid,
   output logic              ins_ready,
   input  logic [31:0]       ins,
   output logic              done,
   output logic              err,
   output logic              busy,
   input  logic [4:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] sgpr,
   output logic              sat,
   output logic [1:0]        state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, WB = 2'd3} state_t;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;

   state_t              state;
   logic [DATA_W-1:0]   gpr [32];
   logic [DATA_W-1:0]   sgpr_q;
   logic [26:0]         ins_q;
   logic [DATA_W-1:0]   res_q;
   logic                wr_pend_q;
   logic                mul_pend_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [2*DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic [5:0]          iter_q;

   function automatic logic in_range(input logic [4:0] a);
      return {1'b0, a} < 6'(NREG);
   endfunction

   function automatic logic [DATA_W-1:0] op2_of(input logic [31:0] w);
      logic [31:0] imm32;
      imm32 = {16'h0000, w[15:0]};
      return w[16] ? imm32[DATA_W-1:0] : gpr[w[15:11]];
   endfunction

   // Handshake: an instruction transfers on the rising edge where ins_valid && ins_ready;
   // ins_ready is high only in IDLE, and a source must hold ins stable until that edge.
   assign ins_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign sgpr      = sgpr_q;
   assign rd_data   = in_range(rd_addr) ? gpr[rd_addr] : '0;

   logic [4:0]        opc;
   logic              bad_c;
   logic [DATA_W-1:0] op1_c, op2_c, res_c;
`ifdef AU_SAT_EN
   logic [DATA_W:0]   sum_c, diff_c;
   logic              sat_c;
   logic              sat_q;
   assign sat = sat_q;
`else
   logic [DATA_W-1:0] sum_c, diff_c;
   assign sat = 1'b0;
`endif

   assign opc = ins[31:27];

   // Result of a single-cycle op is computed from the offered word, so it is ready at accept.
   always_comb begin
      op1_c  = gpr[ins[21:17]];
      op2_c  = op2_of(ins);
      bad_c  = (opc > OP_MUL) || !in_range(ins[26:22]) || !in_range(ins[21:17]) ||
               (!ins[16] && !in_range(ins[15:11]));
`ifdef AU_SAT_EN
      sum_c  = {1'b0, op1_c} + {1'b0, op2_c};
      diff_c = {1'b0, op1_c} - {1'b0, op2_c};
      sat_c  = 1'b0;
`else
      sum_c  = op1_c + op2_c;
      diff_c = op1_c - op2_c;
`endif
      res_c  = '0;
      case (opc)
         OP_MOVSGPR: res_c = sgpr_q;
         OP_MOV:     res_c = ins[16] ? op2_c : op1_c;
         OP_ADD:     res_c = sum_c[DATA_W-1:0];
         OP_SUB:     res_c = diff_c[DATA_W-1:0];
         default:    res_c = '0;
      endcase
`ifdef AU_SAT_EN
      if (opc == OP_ADD && sum_c[DATA_W]) begin
         res_c = '1;
         sat_c = 1'b1;
      end
      if (opc == OP_SUB && diff_c[DATA_W]) begin
         res_c = '0;
         sat_c = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         for (int i = 0; i < 32; i++) gpr[i] <= '0;
         sgpr_q     <= '0;
         ins_q      <= '0;
         res_q      <= '0;
         wr_pend_q  <= 1'b0;
         mul_pend_q <= 1'b0;
         prod_q     <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         iter_q     <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef AU_SAT_EN
         sat_q      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef AU_SAT_EN
         sat_q <= 1'b0;
`endif
         case (state)
            IDLE: if (ins_valid) begin
               ins_q      <= ins[26:0];
               res_q      <= res_c;
               state      <= EXEC;
               wr_pend_q  <= !bad_c && (opc != OP_MUL);
               mul_pend_q <= !bad_c && (opc == OP_MUL);
               done       <= bad_c || (opc != OP_MUL);
               err        <= bad_c;
`ifdef AU_SAT_EN
               sat_q      <= !bad_c && sat_c;
`endif
            end
            EXEC: begin
               if (wr_pend_q) gpr[ins_q[26:22]] <= res_q;
               if (mul_pend_q) begin
                  mcand_q  <= {{DATA_W{1'b0}}, gpr[ins_q[21:17]]};
                  mplier_q <= op2_of({5'b00000, ins_q});
                  prod_q   <= '0;
                  iter_q   <= '0;
                  state    <= MUL;
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (mplier_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               iter_q   <= iter_q + 6'd1;
               if (iter_q == 6'(DATA_W - 1)) begin
                  state <= WB;
                  done  <= 1'b1;
               end
            end
            WB: begin
               gpr[ins_q[26:22]] <= prod_q[DATA_W-1:0];
               sgpr_q            <= prod_q[2*DATA_W-1:DATA_W];
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc_core.sv
// Directed testbench for alu_mc_core (DATA_W=16, NREG=8); expectations follow AU_SAT_EN when defined.
module tb_alu_mc_core;
   timeunit 1ns;
   timeprecision 100ps;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam logic [4:0] OP_MOVSGPR = 5'd0, OP_MOV = 5'd1, OP_ADD = 5'd2;
   localparam logic [4:0] OP_SUB = 5'd3, OP_MUL = 5'd4, OP_ILL = 5'h1F;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ins_valid = 1'b0;
   logic [31:0]       ins = '0;
   logic [4:0]        rd_addr = '0;
   logic              ins_ready, done, err, busy, sat;
   logic [DATA_W-1:0] rd_data, sgpr;
   logic [1:0]        state_dbg;

   int                vec_cnt = 0;
   int                err_cnt = 0;
   logic [DATA_W-1:0] model [NREG];
   logic [DATA_W-1:0] exp_sgpr;

   always #5 clk = ~clk;

   alu_mc_core #(.DATA_W(DATA_W), .NREG(NREG)) dut (
      .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
      .done(done), .err(err), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
      .sgpr(sgpr), .sat(sat), .state_dbg(state_dbg)
   );

   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, 1'b1, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, 1'b0, rs2, 11'h000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and return 1 ns after the edge that accepted it.
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      ins_valid = 1'b1;
      ins = w;
      while (!ins_ready && n < 50) begin
         step();
         n++;
      end
      vec_cnt++;
      if (n >= 50) begin
         err_cnt++;
         $display("FAIL send_timeout: ins_ready=%0b after %0d cycles, required 1", ins_ready, n);
      end
      step();
      ins_valid = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NREG; i++) model[i] = '0;
      exp_sgpr = '0;
      rst_n = 1'b0;
      step();
      step();
      vec_cnt++;
      if (ins_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sat !== 1'b0 ||
          state_dbg !== 2'd0) begin
         err_cnt++;
         $display("FAIL reset_ctrl: ready=%b busy=%b done=%b err=%b sat=%b st=%0d, required 1 0 0 0 0 0",
                  ins_ready, busy, done, err, sat, state_dbg);
      end
      vec_cnt++;
      if (sgpr !== 16'h0000) begin
         err_cnt++;
         $display("FAIL reset_sgpr: got %h, expected 0000", sgpr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_mov_add();
      send(enc_i(OP_MOV, 5'd1, 5'd0, 16'h1234));
      vec_cnt++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL mov_done: done=%b err=%b busy=%b, required 1 0 1", done, err, busy);
      end
      step();
      vec_cnt++;
      if (done !== 1'b0 || ins_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL mov_retire: done=%b ready=%b, required 0 1", done, ins_ready);
      end
      rd_addr = 5'd1; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h1234) begin
         err_cnt++;
         $display("FAIL mov_r1: got %h, expected 1234", rd_data);
      end
      model[1] = 16'h1234;

      send(enc_i(OP_ADD, 5'd2, 5'd1, 16'h0001));
      vec_cnt++;
      if (done !== 1'b1 || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL add_done: done=%b err=%b, required 1 0", done, err);
      end
      step();
      rd_addr = 5'd2; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h1235) begin
         err_cnt++;
         $display("FAIL add_r2: got %h, expected 1235", rd_data);
      end
      model[2] = 16'h1235;

      send(enc_r(OP_SUB, 5'd3, 5'd2, 5'd1));
      step();
      send(enc_r(OP_ADD, 5'd3, 5'd3, 5'd3));
      step();
      rd_addr = 5'd3; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h0002) begin
         err_cnt++;
         $display("FAIL sub_add_self_r3: got %h, expected 0002", rd_data);
      end
      model[3] = 16'h0002;

      send(enc_r(OP_MOV, 5'd7, 5'd2, 5'd0));
      step();
      rd_addr = 5'd7; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h1235) begin
         err_cnt++;
         $display("FAIL mov_reg_r7: got %h, expected 1235", rd_data);
      end
      model[7] = 16'h1235;
   endtask

   task automatic test_mul();
      int n;
      send(enc_i(OP_MOV, 5'd3, 5'd0, 16'h0100));
      step();
      model[3] = 16'h0100;
      send(enc_r(OP_MUL, 5'd4, 5'd1, 5'd3));
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      vec_cnt++;
      if (n !== 17 || err !== 1'b0 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL mul_latency: done after %0d edges err=%b busy=%b, required 17 0 1", n, err, busy);
      end
      step();
      rd_addr = 5'd4; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h3400 || sgpr !== 16'h0012 || ins_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL mul_result: r4=%h sgpr=%h ready=%b, required 3400 0012 1", rd_data, sgpr, ins_ready);
      end
      model[4] = 16'h3400;

      send(enc_i(OP_MOVSGPR, 5'd5, 5'd0, 16'h0000));
      step();
      rd_addr = 5'd5; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h0012) begin
         err_cnt++;
         $display("FAIL movsgpr_r5: got %h, expected 0012", rd_data);
      end
      model[5] = 16'h0012;

      send(enc_i(OP_MUL, 5'd6, 5'd1, 16'hFFFF));
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      step();
      rd_addr = 5'd6; #0.1;
      vec_cnt++;
      if (n !== 17 || rd_data !== 16'hEDCC || sgpr !== 16'h1233) begin
         err_cnt++;
         $display("FAIL mul_imm: edges=%0d r6=%h sgpr=%h, required 17 edcc 1233", n, rd_data, sgpr);
      end
      model[6] = 16'hEDCC;
      exp_sgpr = 16'h1233;
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] exp_add, exp_sub;
      logic              exp_sat;
`ifdef AU_SAT_EN
      exp_add = 16'hFFFF; exp_sub = 16'h0000; exp_sat = 1'b1;
`else
      exp_add = 16'h0001; exp_sub = 16'hFFFF; exp_sat = 1'b0;
`endif
      send(enc_i(OP_MOV, 5'd1, 5'd0, 16'hFFFF));
      step();
      model[1] = 16'hFFFF;
      send(enc_i(OP_ADD, 5'd2, 5'd1, 16'h0002));
      vec_cnt++;
      if (done !== 1'b1 || sat !== exp_sat) begin
         err_cnt++;
         $display("FAIL add_ovf_sat: done=%b sat=%b, required 1 %b", done, sat, exp_sat);
      end
      step();
      rd_addr = 5'd2; #0.1;
      vec_cnt++;
      if (rd_data !== exp_add) begin
         err_cnt++;
         $display("FAIL add_ovf_r2: got %h, expected %h", rd_data, exp_add);
      end
      model[2] = exp_add;
      send(enc_i(OP_SUB, 5'd6, 5'd0, 16'h0001));
      vec_cnt++;
      if (sat !== exp_sat) begin
         err_cnt++;
         $display("FAIL sub_borrow_sat: got %b, expected %b", sat, exp_sat);
      end
      step();
      rd_addr = 5'd6; #0.1;
      vec_cnt++;
      if (rd_data !== exp_sub) begin
         err_cnt++;
         $display("FAIL sub_borrow_r6: got %h, expected %h", rd_data, exp_sub);
      end
      model[6] = exp_sub;
   endtask

   task automatic test_illegal();
      logic [31:0] bad_w [3];
      bad_w[0] = enc_i(OP_ILL, 5'd1, 5'd1, 16'h5555);
      bad_w[1] = enc_i(OP_MOV, 5'd9, 5'd0, 16'h00AA);
      bad_w[2] = enc_r(OP_ADD, 5'd1, 5'd1, 5'd8);
      for (int k = 0; k < 3; k++) begin
         send(bad_w[k]);
         vec_cnt++;
         if (done !== 1'b1 || err !== 1'b1 || sat !== 1'b0) begin
            err_cnt++;
            $display("FAIL illegal_%0d_pulse: done=%b err=%b sat=%b, required 1 1 0", k, done, err, sat);
         end
         step();
         vec_cnt++;
         if (done !== 1'b0 || err !== 1'b0 || ins_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL illegal_%0d_retire: done=%b err=%b ready=%b, required 0 0 1", k, done, err, ins_ready);
         end
      end
      for (int i = 0; i < NREG; i++) begin
         rd_addr = 5'(i); #0.1;
         vec_cnt++;
         if (rd_data !== model[i]) begin
            err_cnt++;
            $display("FAIL illegal_keep_r%0d: got %h, expected %h", i, rd_data, model[i]);
         end
      end
      rd_addr = 5'd9; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h0000 || sgpr !== exp_sgpr) begin
         err_cnt++;
         $display("FAIL illegal_oob_sgpr: r9=%h sgpr=%h, required 0000 %h", rd_data, sgpr, exp_sgpr);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      logic        acc;
      int          dn, idx, n;
      words[0] = enc_i(OP_MOV, 5'd3, 5'd0, 16'h0005);
      words[1] = enc_i(OP_ADD, 5'd4, 5'd3, 16'h0010);
      words[2] = enc_i(OP_MUL, 5'd5, 5'd3, 16'h0003);
      words[3] = enc_r(OP_MOV, 5'd6, 5'd5, 5'd0);
      dn = 0; idx = 0; n = 0;
      ins = words[0];
      ins_valid = 1'b1;
      while ((idx < 4 || busy) && n < 80) begin
         acc = ins_ready & ins_valid;
         step();
         n++;
         if (done) dn++;
         if (acc) begin
            idx++;
            if (idx < 4) ins = words[idx];
            else ins_valid = 1'b0;
         end
      end
      ins_valid = 1'b0;
      vec_cnt++;
      if (dn !== 4 || idx !== 4) begin
         err_cnt++;
         $display("FAIL b2b_count: done pulses=%0d accepts=%0d, required 4 4", dn, idx);
      end
      model[3] = 16'h0005; model[4] = 16'h0015; model[5] = 16'h000F; model[6] = 16'h000F;
      exp_sgpr = 16'h0000;
      for (int i = 3; i < 7; i++) begin
         rd_addr = 5'(i); #0.1;
         vec_cnt++;
         if (rd_data !== model[i]) begin
            err_cnt++;
            $display("FAIL b2b_r%0d: got %h, expected %h", i, rd_data, model[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int dn;
      send(enc_r(OP_MUL, 5'd4, 5'd1, 5'd3));
      repeat (7) step();
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (ins_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0 || sgpr !== 16'h0000) begin
         err_cnt++;
         $display("FAIL abort_ctrl: ready=%b busy=%b done=%b st=%0d sgpr=%h, required 1 0 0 0 0000",
                  ins_ready, busy, done, state_dbg, sgpr);
      end
      for (int i = 0; i < NREG; i++) model[i] = '0;
      for (int i = 0; i < NREG; i++) begin
         rd_addr = 5'(i); #0.1;
         vec_cnt++;
         if (rd_data !== model[i]) begin
            err_cnt++;
            $display("FAIL abort_clear_r%0d: got %h, expected 0000", i, rd_data);
         end
      end
      dn = 0;
      repeat (3) begin
         step();
         if (done) dn++;
      end
      vec_cnt++;
      if (dn !== 0) begin
         err_cnt++;
         $display("FAIL abort_no_done: %0d done pulses, required 0", dn);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(enc_i(OP_MOV, 5'd2, 5'd0, 16'h00AB));
      vec_cnt++;
      if (done !== 1'b1 || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL first_accept: done=%b err=%b, required 1 0", done, err);
      end
      step();
      rd_addr = 5'd2; #0.1;
      vec_cnt++;
      if (rd_data !== 16'h00AB) begin
         err_cnt++;
         $display("FAIL first_accept_r2: got %h, expected 00ab", rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_mov_add();
      test_mul();
      test_wrap();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
      $fatal(1, "watchdog expired");
   end
endmodule
